// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences RF/DM/PC resets after power-up or RESET, then gates CPU execution
// through CPU_EN under RUN (optionally budgeted), STEP and HALT commands from a debug host.
module cpu_run_controller #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD,
  input  logic [CNT_W-1:0] BUDGET,
  output logic             RFRST,
  output logic             DMRST,
  output logic             PCRRST,
  output logic             CPU_EN,
  output logic             DONE,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] CYCLE_CNT
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [1:0] C_RESET = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_HALT = 2'd3;
  typedef enum logic [2:0] {S_HOLD = 3'd0, S_PC = 3'd1, S_IDLE = 3'd2, S_RUN = 3'd3, S_STEP = 3'd4} state_t;
  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rem;
  logic             r_done;
  logic             w_acc;
  assign w_acc     = CMD_VALID && CMD_READY;
  assign RFRST     = r_state == S_HOLD;
  assign DMRST     = r_state == S_HOLD;
  assign PCRRST    = r_state == S_HOLD || r_state == S_PC;
  assign CPU_EN    = r_state == S_RUN || r_state == S_STEP;
  assign CMD_READY = r_state == S_IDLE || r_state == S_RUN;
  assign DONE      = r_done;
  assign STATE     = r_state;
  assign CYCLE_CNT = r_cnt;
  // A nonzero remaining count inside RUN means the run is bounded; unbounded runs keep it at 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_HOLD;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_HOLD: begin
          r_hold  <= (r_hold == HW'(RST_CYCLES - 1)) ? '0 : r_hold + 1'b1;
          r_state <= (r_hold == HW'(RST_CYCLES - 1)) ? S_PC : S_HOLD;
        end
        S_PC: r_state <= S_IDLE;
        S_IDLE: begin
          if (w_acc && CMD == C_RESET) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else if (w_acc && CMD == C_RUN) begin
            r_state <= S_RUN;
            r_rem   <= BUDGET;
          end else if (w_acc && CMD == C_STEP) begin
            r_state <= S_STEP;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_rem != '0) r_rem <= r_rem - 1'b1;
          if (w_acc && CMD == C_RESET) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else if (r_rem == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_acc && CMD == C_HALT) begin
            r_state <= S_IDLE;
          end
        end
        S_STEP: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: randomized transactions against a transaction-level model; a monitor
// checks every CPU_EN burst length and every DONE pulse against scoreboard queues.
module tb_cpu_run_controller;
  localparam logic [1:0] C_RESET = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_HALT = 2'd3;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD = 2'd0;
  logic [3:0] BUDGET = 4'd0;
  logic       RFRST, DMRST, PCRRST, CPU_EN, DONE;
  logic [2:0] STATE;
  logic [3:0] CYCLE_CNT;
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int run_len = 0;
  int m_cnt = 0;
  int exp_len[$];
  int exp_done[$];

  cpu_run_controller #(.RST_CYCLES(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD(CMD),
    .BUDGET(BUDGET), .RFRST(RFRST), .DMRST(DMRST), .PCRRST(PCRRST), .CPU_EN(CPU_EN),
    .DONE(DONE), .STATE(STATE), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (CPU_EN) run_len++;
    else if (run_len > 0) begin
      if (exp_len.size() > 0) chk("run_len", run_len, exp_len.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL unexpected_run actual=%0d required=none t=%0t", run_len, $time);
      end
      run_len = 0;
    end
    if (DONE) begin
      if (exp_done.size() > 0) chk("done_cnt", CYCLE_CNT, exp_done.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end
    end
  end

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [1:0] c, input int b, output int acc);
    int t = 0;
    logic rdy;
    CMD_VALID = 1'b1; CMD = c; BUDGET = b[3:0];
    do begin
      @(negedge CLK); rdy = CMD_READY;
      @(posedge CLK); #1; t++;
    end while (!rdy && t < 50);
    CMD_VALID = 1'b0;
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted cmd=%0d", c);
    end
    acc = edge_n;
  endtask

  task automatic check_seq();
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(posedge CLK);
      @(negedge CLK);
      chk("rfrst", RFRST, j < 4);
      chk("dmrst", DMRST, j < 4);
      chk("pcrrst", PCRRST, j < 5);
      chk("seq_ready", CMD_READY, j >= 5);
      chk("seq_state", STATE, j < 4 ? 0 : (j == 4 ? 1 : 2));
      chk("seq_en", CPU_EN, 0);
    end
    chk("cnt_clear", CYCLE_CNT, 0);
    @(posedge CLK); #1;
  endtask

  task automatic run_then(input int n, input int l, input logic [1:0] c2);
    int k, a, en;
    bit bnd, dn;
    bnd = n != 0;
    en = (bnd && l > n) ? n : l;
    dn = bnd && ((c2 == C_HALT) ? l >= n : l > n);
    send(C_RUN, n, k);
    exp_len.push_back(en);
    m_cnt = (m_cnt + en) % 16;
    if (dn) exp_done.push_back(m_cnt);
    repeat (l - 1) @(posedge CLK);
    #1;
    send(c2, 0, a);
    chk("accept_edge", a - k, l);
    if (c2 == C_RESET) begin
      m_cnt = 0;
      check_seq();
    end else begin
      @(negedge CLK);
      chk("halt_state", STATE, 2);
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_step();
    int k;
    m_cnt = (m_cnt + 1) % 16;
    exp_len.push_back(1);
    exp_done.push_back(m_cnt);
    send(C_STEP, 0, k);
    @(posedge CLK); #1;
  endtask

  task automatic step3();
    for (int i = 1; i <= 3; i++) begin
      exp_len.push_back(1);
      exp_done.push_back((m_cnt + i) % 16);
    end
    m_cnt = (m_cnt + 3) % 16;
    CMD_VALID = 1'b1; CMD = C_STEP;
    @(negedge CLK); chk("step_ready0", CMD_READY, 1);
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("step_en", CPU_EN, i % 2 == 0);
      chk("step_ready", CMD_READY, i % 2 == 1);
      @(posedge CLK); #1;
    end
    CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("step_en_last", CPU_EN, 1);
    chk("step_ready_last", CMD_READY, 0);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset_cmd();
    int k;
    send(C_RESET, 0, k);
    m_cnt = 0;
    check_seq();
  endtask

  task automatic async_rst(input int j);
    int k;
    send(C_RUN, 0, k);
    exp_len.push_back(j);
    repeat (j) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("async_en", CPU_EN, 0);
    chk("async_state", STATE, 0);
    m_cnt = 0;
    @(posedge CLK); #1 RST = 1'b0;
    check_seq();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rfrst", RFRST, 1);
    chk("rst_pcrrst", PCRRST, 1);
    chk("rst_en", CPU_EN, 0);
    chk("rst_ready", CMD_READY, 0);
    chk("rst_state", STATE, 0);
    chk("rst_cnt", CYCLE_CNT, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    check_seq();
    run_then(10, 12, C_HALT);
    chk("run10_cnt", CYCLE_CNT, 10);
    step3();
    run_then(0, 7, C_HALT);
    do_reset_cmd();
    run_then(5, 5, C_RESET);
    run_then(5, 5, C_HALT);
    do_reset_cmd();
    run_then(0, 17, C_HALT);
    chk("wrap_cnt", CYCLE_CNT, 1);
    async_rst(3);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: do_step();
        1: begin n = $urandom_range(1, 15); run_then(n, $urandom_range(1, n + 3), C_HALT); end
        2: run_then(0, $urandom_range(1, 20), C_HALT);
        3: begin n = $urandom_range(0, 15); run_then(n, $urandom_range(1, n == 0 ? 20 : n + 3), C_RESET); end
        4: begin
          send(C_HALT, 0, k);
          @(negedge CLK);
          chk("idle_halt_state", STATE, 2);
          chk("idle_halt_en", CPU_EN, 0);
          @(posedge CLK); #1;
        end
        default: async_rst($urandom_range(1, 6));
      endcase
    end
    repeat (5) @(posedge CLK);
    #1;
    chk("final_cnt", CYCLE_CNT, m_cnt);
    chk("len_q_left", exp_len.size(), 0);
    chk("done_q_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
